// File: rtl/stage_skid_reg.sv
// Handshaked pipeline stage register: 2-entry skid buffer (MODE=0) or half-rate
// single register (MODE=1), with synchronous flush and registered outputs only.
module stage_skid_reg #(
    parameter int                  DATA_W  = 64,
    parameter int                  MODE    = 0,
    parameter logic [DATA_W-1:0]   RST_VAL = '0
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_flush,
    input  logic              i_up_valid,
    output logic              o_up_ready,
    input  logic [DATA_W-1:0] i_up_data,
    output logic              o_dn_valid,
    input  logic              i_dn_ready,
    output logic [DATA_W-1:0] o_dn_data,
    output logic [1:0]        o_occupancy
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              up_ready_q,   up_ready_d;
    logic              up_fire;
    logic              dn_fire;

    assign up_fire = i_up_valid & up_ready_q;
    assign dn_fire = main_valid_q & i_dn_ready;

    // Main entry: the only register the downstream ever sees.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (i_flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_VAL;
        end else if (!main_valid_q) begin
            if (up_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = i_up_data;
            end
        end else if (skid_valid_q) begin
            if (dn_fire) begin
                main_data_d = skid_data_q;
            end
        end else if (up_fire && dn_fire) begin
            main_data_d = i_up_data;
        end else if (dn_fire) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RST_VAL;
            up_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            up_ready_q   <= up_ready_d;
        end
    end

    generate
        if (MODE == 0) begin : g_skid
            logic              skid_valid_d;
            logic [DATA_W-1:0] skid_data_d;

            // Skid catches the beat that arrives while main is stalled.
            always_comb begin
                skid_valid_d = skid_valid_q;
                skid_data_d  = skid_data_q;
                if (i_flush) begin
                    skid_valid_d = 1'b0;
                    skid_data_d  = RST_VAL;
                end else if (main_valid_q && !skid_valid_q && up_fire && !dn_fire) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = i_up_data;
                end else if (skid_valid_q && dn_fire) begin
                    skid_valid_d = 1'b0;
                end
            end

            always_ff @(posedge i_sys_clk) begin
                if (i_sys_rst) begin
                    skid_valid_q <= 1'b0;
                    skid_data_q  <= RST_VAL;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    skid_data_q  <= skid_data_d;
                end
            end

            assign up_ready_d = !(main_valid_d && skid_valid_d);
        end else begin : g_single
            assign skid_valid_q = 1'b0;
            assign skid_data_q  = RST_VAL;
            assign up_ready_d   = !main_valid_d;
        end
    endgenerate

    assign o_up_ready  = up_ready_q;
    assign o_dn_valid  = main_valid_q;
    assign o_dn_data   = main_data_q;
    assign o_occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifndef SYNTHESIS
    localparam logic [1:0] MAX_OCC = (MODE == 0) ? 2'd2 : 2'd1;

    a_occ_bound: assert property (@(posedge i_sys_clk) disable iff (i_sys_rst)
        o_occupancy <= MAX_OCC);

    a_no_fire_full: assert property (@(posedge i_sys_clk) disable iff (i_sys_rst)
        !(up_fire && main_valid_q && skid_valid_q));

    a_dn_stable: assert property (@(posedge i_sys_clk) disable iff (i_sys_rst)
        (o_dn_valid && !i_dn_ready && !i_flush && !i_sys_rst) |=> $stable(o_dn_data));
`endif

endmodule

// File: tb/tb_stage_skid_reg.sv
// Directed bench for stage_skid_reg: MODE=0 (64b and 8b random/reset) and MODE=1 half-rate.
module tb_stage_skid_reg;

    localparam logic [63:0] RV0 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [7:0]  RV8 = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // MODE=0, 64-bit
    logic        rst0 = 1'b1, flush0 = 1'b0, uv0 = 1'b0, dr0 = 1'b0;
    logic [63:0] ud0 = '0;
    logic        ur0, dv0;
    logic [63:0] dd0;
    logic [1:0]  occ0;

    // MODE=1, 64-bit
    logic        rst1 = 1'b1, flush1 = 1'b0, uv1 = 1'b0, dr1 = 1'b0;
    logic [63:0] ud1 = '0;
    logic        ur1, dv1;
    logic [63:0] dd1;
    logic [1:0]  occ1;

    // MODE=0, 8-bit
    logic        rst8 = 1'b1, flush8 = 1'b0, uv8 = 1'b0, dr8 = 1'b0;
    logic [7:0]  ud8 = '0;
    logic        ur8, dv8;
    logic [7:0]  dd8;
    logic [1:0]  occ8;

    stage_skid_reg #(.DATA_W(64), .MODE(0), .RST_VAL(RV0)) u_dut0 (
        .i_sys_clk(clk), .i_sys_rst(rst0), .i_flush(flush0),
        .i_up_valid(uv0), .o_up_ready(ur0), .i_up_data(ud0),
        .o_dn_valid(dv0), .i_dn_ready(dr0), .o_dn_data(dd0), .o_occupancy(occ0));

    stage_skid_reg #(.DATA_W(64), .MODE(1), .RST_VAL(64'h0)) u_dut1 (
        .i_sys_clk(clk), .i_sys_rst(rst1), .i_flush(flush1),
        .i_up_valid(uv1), .o_up_ready(ur1), .i_up_data(ud1),
        .o_dn_valid(dv1), .i_dn_ready(dr1), .o_dn_data(dd1), .o_occupancy(occ1));

    stage_skid_reg #(.DATA_W(8), .MODE(0), .RST_VAL(RV8)) u_dut8 (
        .i_sys_clk(clk), .i_sys_rst(rst8), .i_flush(flush8),
        .i_up_valid(uv8), .o_up_ready(ur8), .i_up_data(ud8),
        .o_dn_valid(dv8), .i_dn_ready(dr8), .o_dn_data(dd8), .o_occupancy(occ8));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sb_q[$];
    logic [7:0] exp_b;
    bit         up_f, dn_f;
    int         beat_idx;

    initial begin
        // ---------------- reset (MODE=0 and MODE=1) ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_ready0", 64'(ur0), 64'd0);
            check_eq("rst_valid0", 64'(dv0), 64'd0);
            check_eq("rst_data0", dd0, RV0);
            check_eq("rst_occ0", 64'(occ0), 64'd0);
            check_eq("rst_ready1", 64'(ur1), 64'd0);
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        tick();
        check_eq("rel_ready0", 64'(ur0), 64'd1);
        check_eq("rel_ready1", 64'(ur1), 64'd1);

        // ---------------- stream 0x10..0x17, MODE=0 ----------------
        dr0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            uv0 = 1'b1;
            ud0 = 64'h10 + 64'(i);
            tick();
            $display("stream beat out %0h occ %0d", dd0, occ0);
            check_eq("stream_valid", 64'(dv0), 64'd1);
            check_eq("stream_data", dd0, 64'h10 + 64'(i));
            check_eq("stream_occ", 64'(occ0), 64'd1);
            check_eq("stream_ready", 64'(ur0), 64'd1);
        end
        uv0 = 1'b0;
        tick();
        check_eq("stream_drain_valid", 64'(dv0), 64'd0);
        check_eq("stream_drain_occ", 64'(occ0), 64'd0);

        // ---------------- backpressure skid, MODE=0 ----------------
        uv0 = 1'b1; ud0 = 64'hA0;
        tick();
        check_eq("bp_a0_out", dd0, 64'hA0);
        dr0 = 1'b0; ud0 = 64'hA1;
        tick();
        check_eq("bp_occ2", 64'(occ0), 64'd2);
        check_eq("bp_ready0", 64'(ur0), 64'd0);
        check_eq("bp_hold_a0", dd0, 64'hA0);
        ud0 = 64'hA2;
        tick();
        check_eq("bp_hold_occ", 64'(occ0), 64'd2);
        check_eq("bp_hold_data", dd0, 64'hA0);
        dr0 = 1'b1;
        tick();
        check_eq("bp_a1_out", dd0, 64'hA1);
        check_eq("bp_a1_occ", 64'(occ0), 64'd1);
        check_eq("bp_a1_ready", 64'(ur0), 64'd1);
        tick();
        check_eq("bp_a2_out", dd0, 64'hA2);
        check_eq("bp_a2_occ", 64'(occ0), 64'd1);
        uv0 = 1'b0;
        tick();
        check_eq("bp_empty_occ", 64'(occ0), 64'd0);
        check_eq("bp_empty_hold", dd0, 64'hA2);

        // ---------------- simultaneous fire in ONE ----------------
        dr0 = 1'b0; uv0 = 1'b1; ud0 = 64'h01;
        tick();
        check_eq("sim_01", dd0, 64'h01);
        ud0 = 64'h02; dr0 = 1'b1;
        tick();
        check_eq("sim_02", dd0, 64'h02);
        check_eq("sim_occ1", 64'(occ0), 64'd1);
        check_eq("sim_ready", 64'(ur0), 64'd1);
        uv0 = 1'b0;
        tick();
        check_eq("sim_drain", 64'(occ0), 64'd0);

        // ---------------- flush in FULL ----------------
        dr0 = 1'b0; uv0 = 1'b1; ud0 = 64'h55;
        tick();
        ud0 = 64'h66;
        tick();
        check_eq("fl_full", 64'(occ0), 64'd2);
        ud0 = 64'h77; flush0 = 1'b1;
        tick();
        flush0 = 1'b0; uv0 = 1'b0; dr0 = 1'b1;
        check_eq("fl_valid", 64'(dv0), 64'd0);
        check_eq("fl_occ", 64'(occ0), 64'd0);
        check_eq("fl_data", dd0, RV0);
        check_eq("fl_ready", 64'(ur0), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("fl_no77", 64'(dv0), 64'd0);
        end

        // ---------------- half-rate, MODE=1 ----------------
        dr1 = 1'b1; uv1 = 1'b1; beat_idx = 0; ud1 = 64'hC0;
        check_eq("hr_ready_pre", 64'(ur1), 64'd1);
        for (int c = 1; c <= 8; c++) begin
            up_f = uv1 && ur1;
            tick();
            if (up_f) begin
                beat_idx++;
                ud1 = 64'hC0 + 64'(beat_idx);
                if (beat_idx == 4) uv1 = 1'b0;
            end
            check_eq("hr_ready", 64'(ur1), (c % 2 == 0) ? 64'd1 : 64'd0);
            check_eq("hr_valid", 64'(dv1), (c % 2 == 1) ? 64'd1 : 64'd0);
            check_eq("hr_occ", 64'(occ1), (c % 2 == 1) ? 64'd1 : 64'd0);
            if (c % 2 == 1) begin
                $display("half-rate beat out %0h", dd1);
                check_eq("hr_data", dd1, 64'hC0 + 64'((c - 1) / 2));
            end
        end
        check_eq("hr_all_accepted", 64'(beat_idx), 64'd4);

        // ---------------- random with mid-run reset, MODE=0 8-bit ----------------
        rst8 = 1'b0;
        tick();
        check_eq("r8_ready", 64'(ur8), 64'd1);
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc == 250) begin
                check_eq("r8_full_at_rst", 64'(occ8), 64'd2);
                rst8 = 1'b1; uv8 = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check_eq("r8_rst_valid", 64'(dv8), 64'd0);
                    check_eq("r8_rst_data", 64'(dd8), 64'(RV8));
                    check_eq("r8_rst_ready", 64'(ur8), 64'd0);
                    check_eq("r8_rst_occ", 64'(occ8), 64'd0);
                end
                sb_q.delete();
                rst8 = 1'b0;
                tick();
                check_eq("r8_restart_ready", 64'(ur8), 64'd1);
            end
            if (cyc >= 240 && cyc < 250) begin
                if (!uv8) ud8 = 8'($urandom);
                uv8 = 1'b1;
                dr8 = 1'b0;
            end else begin
                if (!uv8) begin
                    uv8 = 1'($urandom_range(0, 1));
                    ud8 = 8'($urandom);
                end
                dr8 = ($urandom_range(0, 3) != 0);
            end
            up_f = uv8 && ur8;
            dn_f = dv8 && dr8;
            if (dn_f) begin
                if (sb_q.size() == 0) begin
                    check_eq("r8_spurious", 64'(dv8), 64'd0);
                end else begin
                    exp_b = sb_q.pop_front();
                    $display("random beat out %0h", dd8);
                    check_eq("r8_data", 64'(dd8), 64'(exp_b));
                end
            end
            tick();
            if (up_f) begin
                sb_q.push_back(ud8);
                uv8 = 1'b0;
            end
            check_eq("r8_occ", 64'(occ8), 64'(sb_q.size()));
        end
        uv8 = 1'b0; dr8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (dv8) begin
                exp_b = (sb_q.size() != 0) ? sb_q.pop_front() : ~dd8;
                check_eq("r8_drain_data", 64'(dd8), 64'(exp_b));
            end
            tick();
        end
        check_eq("r8_drain_occ", 64'(occ8), 64'd0);
        check_eq("r8_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
